// File: rtl/expr_calc.sv
// expr_calc: grammar-checking evaluator for a one-character-per-cycle ASCII stream of single
// digits joined by '+' and '*', terminated by '='. '*' binds tighter than '+'; all arithmetic
// wraps modulo 2^WIDTH. The block re-arms itself after every '='.
//
// Ports:
//   clk      - clock, rising edge
//   clr      - asynchronous active-high reset
//   in       - ASCII character
//   in_valid - 'in' is consumed on edges where this is 1
//   out      - 1 while the accepted prefix is a complete valid expression
//   busy     - 1 while an expression is in progress
//   done     - one-cycle pulse: expression ended validly, 'result' updated
//   err      - one-cycle pulse: expression ended invalidly, 'result' untouched
//   result   - value of the last valid expression
module expr_calc #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        StExpDig,
        StExpOp,
        StErr
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mul_q, mul_d;
    logic [LenW-1:0]  len_q, len_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             is_digit, is_eq, is_plus, is_star, len_full;
    logic [7:0]       digit_raw;
    logic [WIDTH-1:0] digit;

    assign is_digit  = (in >= 8'h30) && (in <= 8'h39);
    assign is_eq     = (in == 8'h3d);
    assign is_plus   = (in == 8'h2b);
    assign is_star   = (in == 8'h2a);
    assign digit_raw = in - 8'h30;
    assign digit     = WIDTH'(digit_raw);
    // Another accepted character would push the count past MAX_LEN.
    assign len_full  = (len_q == LenW'(MAX_LEN));

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        term_d   = term_q;
        mul_d    = mul_q;
        len_d    = len_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (in_valid) begin
            if (is_eq) begin
                // Every terminator re-arms the datapath; only a clean EXP_OP end publishes.
                sum_d   = '0;
                term_d  = '0;
                mul_d   = 1'b0;
                len_d   = '0;
                state_d = StExpDig;
                if (state_q == StExpOp) begin
                    result_d = sum_q + term_q;
                    done_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (state_q)
                    StExpDig: begin
                        if (len_full) begin
                            state_d = StErr;
                        end else begin
                            len_d = len_q + LenW'(1);
                            if (is_digit) begin
                                term_d  = mul_q ? term_q * digit : digit;
                                state_d = StExpOp;
                            end else begin
                                state_d = StErr;
                            end
                        end
                    end
                    StExpOp: begin
                        if (len_full) begin
                            state_d = StErr;
                        end else begin
                            len_d = len_q + LenW'(1);
                            if (is_plus) begin
                                sum_d   = sum_q + term_q;
                                mul_d   = 1'b0;
                                state_d = StExpDig;
                            end else if (is_star) begin
                                mul_d   = 1'b1;
                                state_d = StExpDig;
                            end else begin
                                state_d = StErr;
                            end
                        end
                    end
                    StErr: begin
                        // Discard everything until '='.
                    end
                    default: begin
                        state_d = StErr;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StExpDig;
            sum_q    <= '0;
            term_q   <= '0;
            mul_q    <= 1'b0;
            len_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            term_q   <= term_d;
            mul_q    <= mul_d;
            len_q    <= len_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out    = (state_q == StExpOp);
    assign busy   = (state_q != StExpDig) || (len_q != '0);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_expr_calc.sv
// Self-checking bench for expr_calc. Three instances share one character stream:
//   0: WIDTH=16, MAX_LEN=32   1: WIDTH=8, MAX_LEN=32   2: WIDTH=16, MAX_LEN=3
// The reference keeps the raw characters of the current expression and judges them as text.
module tb_expr_calc;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  in_c = 8'h00;
    logic        in_v = 1'b0;
    logic [2:0]  o_out, o_busy, o_done, o_err;
    logic [15:0] res_a, res_c;
    logic [7:0]  res_b;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned ml[3] = '{32, 32, 3};
    int unsigned wd[3] = '{16, 8, 16};
    logic [15:0] m_res[3];
    logic [2:0]  m_done, m_err;
    bq_t         cur;

    always #5 clk = ~clk;

    expr_calc #(.WIDTH(16), .MAX_LEN(32)) u_a (
        .clk(clk), .clr(clr), .in(in_c), .in_valid(in_v),
        .out(o_out[0]), .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]), .result(res_a)
    );
    expr_calc #(.WIDTH(8), .MAX_LEN(32)) u_b (
        .clk(clk), .clr(clr), .in(in_c), .in_valid(in_v),
        .out(o_out[1]), .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]), .result(res_b)
    );
    expr_calc #(.WIDTH(16), .MAX_LEN(3)) u_c (
        .clk(clk), .clr(clr), .in(in_c), .in_valid(in_v),
        .out(o_out[2]), .busy(o_busy[2]), .done(o_done[2]), .err(o_err[2]), .result(res_c)
    );

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == 8'h2b) || (c == 8'h2a);
    endfunction

    // Text so far alternates digit/operator starting with a digit and fits in maxlen.
    function automatic logic prefix_ok(input bq_t q, input int unsigned maxlen);
        if (q.size() > int'(maxlen)) return 1'b0;
        foreach (q[i]) begin
            if ((i % 2) == 0) begin
                if (!is_digit(q[i])) return 1'b0;
            end else begin
                if (!is_op(q[i])) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Sum of products, reduced modulo 2^w.
    function automatic logic [15:0] eval_expr(input bq_t q, input int unsigned w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned sum  = 0;
        longint unsigned prod = 1;
        foreach (q[i]) begin
            if (is_digit(q[i])) prod = (prod * (longint'(q[i]) - 48)) & mask;
            else if (q[i] == 8'h2b) begin
                sum  = (sum + prod) & mask;
                prod = 1;
            end
        end
        return 16'((sum + prod) & mask);
    endfunction

    function automatic logic [15:0] get_res(input int k);
        if (k == 0) return res_a;
        if (k == 1) return {8'h00, res_b};
        return res_c;
    endfunction

    function automatic void model_clear();
        cur.delete();
        m_done = '0;
        m_err  = '0;
        for (int k = 0; k < 3; k++) m_res[k] = '0;
    endfunction

    // One clock: present a character (or idle), advance the reference, compare every instance.
    task automatic step(input logic [7:0] ch, input logic v);
        logic exp_out, exp_busy, ok;
        in_c = ch;
        in_v = v;
        @(posedge clk);
        #1;
        m_done = '0;
        m_err  = '0;
        if (v) begin
            if (ch == 8'h3d) begin
                for (int k = 0; k < 3; k++) begin
                    ok = (cur.size() % 2 == 1) && prefix_ok(cur, ml[k]);
                    if (ok) begin
                        m_done[k] = 1'b1;
                        m_res[k]  = eval_expr(cur, wd[k]);
                    end else begin
                        m_err[k] = 1'b1;
                    end
                end
                cur.delete();
            end else begin
                cur.push_back(ch);
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_out  = (cur.size() % 2 == 1) && prefix_ok(cur, ml[k]);
            exp_busy = (cur.size() != 0);
            n_tests += 5;
            if (o_out[k] !== exp_out) begin
                n_fail++;
                $display("FAIL out[%0d] char=%h v=%b: got %b expected %b", k, ch, v, o_out[k], exp_out);
            end
            if (o_busy[k] !== exp_busy) begin
                n_fail++;
                $display("FAIL busy[%0d] char=%h v=%b: got %b expected %b", k, ch, v, o_busy[k], exp_busy);
            end
            if (o_done[k] !== m_done[k]) begin
                n_fail++;
                $display("FAIL done[%0d] char=%h v=%b: got %b expected %b", k, ch, v, o_done[k], m_done[k]);
            end
            if (o_err[k] !== m_err[k]) begin
                n_fail++;
                $display("FAIL err[%0d] char=%h v=%b: got %b expected %b", k, ch, v, o_err[k], m_err[k]);
            end
            if (get_res(k) !== m_res[k]) begin
                n_fail++;
                $display("FAIL result[%0d] char=%h v=%b: got %0d expected %0d", k, ch, v, get_res(k), m_res[k]);
            end
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1'b1);
            repeat (gap) step(8'h00, 1'b0);
        end
    endtask

    // Pulse clr between edges and check the outputs clear without waiting for a clock.
    task automatic pulse_clr();
        in_v = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        n_tests += 1;
        if ({o_out, o_busy, o_done, o_err} !== 12'h000 || res_a !== 16'd0 || res_b !== 8'd0
            || res_c !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_async: got out=%b busy=%b done=%b err=%b res=%0d/%0d/%0d expected all 0",
                     o_out, o_busy, o_done, o_err, res_a, res_b, res_c);
        end
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        pulse_clr();
        step(8'h00, 1'b0);
    endtask

    task automatic test_basic();
        send_str("1+2*3=", 0);
        n_tests += 2;
        if (o_done[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: got %b expected 1", o_done[0]);
        end
        if (res_a !== 16'd7) begin
            n_fail++;
            $display("FAIL basic_result: got %0d expected 7", res_a);
        end
        step(8'h00, 1'b0);
    endtask

    task automatic test_gaps();
        send_str("2*3*4+5=", 2);
        n_tests += 1;
        if (res_a !== 16'd29) begin
            n_fail++;
            $display("FAIL gaps_result: got %0d expected 29", res_a);
        end
    endtask

    task automatic test_errors();
        send_str("1+2*3=", 0);
        send_str("1+=", 0);
        send_str("12=", 0);
        n_tests += 1;
        if (res_a !== 16'd7) begin
            n_fail++;
            $display("FAIL errors_result_held: got %0d expected 7", res_a);
        end
        step(8'h00, 1'b0);
    endtask

    task automatic test_wrap();
        send_str("9*9*9*9=", 0);
        n_tests += 2;
        if (res_b !== 8'd161) begin
            n_fail++;
            $display("FAIL wrap_w8: got %0d expected 161", res_b);
        end
        if (res_a !== 16'd6561) begin
            n_fail++;
            $display("FAIL wrap_w16: got %0d expected 6561", res_a);
        end
    endtask

    task automatic test_clr_abort();
        send_str("1+2", 0);
        pulse_clr();
        send_str("4=", 0);
        n_tests += 1;
        if (res_a !== 16'd4) begin
            n_fail++;
            $display("FAIL clr_abort_result: got %0d expected 4", res_a);
        end
        step(8'h00, 1'b0);
    endtask

    task automatic test_maxlen();
        send_str("1+2=", 0);
        n_tests += 1;
        if (res_c !== 16'd3) begin
            n_fail++;
            $display("FAIL maxlen_fit: got %0d expected 3", res_c);
        end
        send_str("1+2+3=", 0);
        n_tests += 1;
        if (o_err[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL maxlen_over_err: got %b expected 1", o_err[2]);
        end
        send_str("5=", 0);
        n_tests += 1;
        if (res_c !== 16'd5) begin
            n_fail++;
            $display("FAIL maxlen_after: got %0d expected 5", res_c);
        end
    endtask

    task automatic test_back_to_back();
        send_str("3===8*8=+ 4=", 0);
        step(8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] junk[5] = '{8'h20, 8'h2b, 8'h2a, 8'h37, 8'h61};
        bq_t e;
        int  nd;
        for (int n = 0; n < 150; n++) begin
            e.delete();
            nd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 20))
                                             : int'($urandom_range(1, 4));
            for (int j = 0; j < nd; j++) begin
                if (j > 0) e.push_back(($urandom_range(0, 1) == 1) ? 8'h2b : 8'h2a);
                e.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end
            if ($urandom_range(0, 7) == 0) e[$urandom_range(0, e.size() - 1)] = junk[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) void'(e.pop_back());
            e.push_back(8'h3d);
            foreach (e[i]) begin
                step(e[i], 1'b1);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step(8'h00, 1'b0);
            end
        end
        step(8'h00, 1'b0);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps();
        test_errors();
        test_wrap();
        test_clr_abort();
        test_maxlen();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
